// File: rtl/select_arb.sv
// select_arb: N-channel selector with fixed-select or round-robin grant and a
// single registered output word with valid/ready handshake.
module select_arb #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rr_en,
    input  logic [SELW-1:0]           sel,
    input  logic                      flush,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready
);

    logic [CHANNELS-1:0][WIDTH-1:0] in_words;
    logic                           out_valid_q, out_valid_d;
    logic [WIDTH-1:0]               out_data_q, out_data_d;
    logic [SELW-1:0]                out_chan_q, out_chan_d;
    logic [SELW-1:0]                ptr_q, ptr_d;
    logic                           load_ok;
    logic                           gnt_vld;
    logic [SELW-1:0]                gnt_idx;
    logic [SELW-1:0]                cand;
    logic                           xfer;

    assign in_words = in_data;

    // The buffer may take a new word when empty or draining this cycle;
    // flush blocks loading so the discarded slot stays empty.
    assign load_ok = !flush && (!out_valid_q || out_ready);
    assign xfer    = load_ok && gnt_vld;

    // Grant selection: fixed index, or first valid channel after ptr (wrapping).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (rr_en) begin
            for (int k = 1; k <= CHANNELS; k++) begin
                cand = SELW'((int'(ptr_q) + k) % CHANNELS);
                if (!gnt_vld && in_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end else begin
            // Compare against each legal index so an out-of-range sel grants nothing.
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end
    end

    // Per-channel accept: one-hot on the granted channel when loading is allowed.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_rdy
        assign in_ready[i] = xfer && (gnt_idx == SELW'(i));
    end

    // Next-state for the output buffer and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_words[gnt_idx];
            out_chan_d  = gnt_idx;
            if (rr_en) begin
                ptr_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; ptr resets to the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= SELW'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_select_arb.sv
// Testbench for select_arb: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_select_arb;

    localparam int W  = 32;
    localparam int C  = 4;
    localparam int SW = 2;

    logic              clk;
    logic              rst_n;
    logic              rr_en;
    logic [SW-1:0]     sel;
    logic              flush;
    logic [C-1:0]      in_valid;
    logic [C-1:0][W-1:0] din;
    logic [C-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_chan;
    logic              out_ready;

    select_arb #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .sel(sel), .flush(flush),
        .in_valid(in_valid), .in_data(din), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit       m_ov;
    bit [W-1:0] m_data;
    int       m_chan;
    int       m_ptr;

    typedef struct {
        logic         rr;
        logic [SW-1:0] sel;
        logic         fl;
        logic [C-1:0] iv;
        logic         ordy;
        logic [C-1:0] e_ir;
        logic         e_ov;
        logic [W-1:0] e_data;
        logic [SW-1:0] e_chan;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov = 0; m_data = '0; m_chan = 0; m_ptr = C - 1;
    endtask

    // Which channel the rules say should be granted right now, or -1.
    function automatic int model_grant();
        if (flush || (m_ov && !out_ready)) return -1;
        if (!rr_en) begin
            if (int'(sel) < C && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= C; k++) begin
            int c = (m_ptr + k) % C;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Before the edge: check accept vector, then advance the model.
    task automatic pre();
        int g;
        logic [C-1:0] er;
        #2;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        if (g >= 0) begin
            m_ov = 1; m_data = din[g]; m_chan = g;
            if (rr_en) m_ptr = g;
        end else if (flush || out_ready) begin
            m_ov = 0;
        end
    endtask

    // After the edge: compare registered outputs with the model.
    task automatic post();
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data",  64'(out_data),  64'(m_data));
        chk("out_chan",  64'(out_chan),  64'(m_chan));
    endtask

    task automatic set_in(input logic rr, input logic [SW-1:0] s, input logic fl,
                          input logic [C-1:0] iv, input logic ordy);
        rr_en = rr; sel = s; flush = fl; in_valid = iv; out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, '0, 0);
        for (int i = 0; i < C; i++) din[i] = 32'hC0DE_0000 + W'(i);
        din[2] = 32'hDEADBEEF;
        model_reset();

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data",  64'(out_data), 0);
        chk("rst_out_chan",  64'(out_chan), 0);
        chk("rst_in_ready",  64'(in_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //         rr sel fl  iv       ordy  e_ir     ov  data           chan
        tbl[0] = '{0, 2, 0, 4'b1111, 1, 4'b0100, 1, 32'hDEADBEEF, 2};
        tbl[1] = '{0, 2, 0, 4'b1011, 1, 4'b0000, 0, 32'hDEADBEEF, 2};
        tbl[2] = '{0, 0, 0, 4'b0001, 0, 4'b0001, 1, 32'hC0DE0000, 0};
        tbl[3] = '{0, 1, 0, 4'b0010, 0, 4'b0000, 1, 32'hC0DE0000, 0};
        tbl[4] = '{0, 1, 1, 4'b0010, 1, 4'b0000, 0, 32'hC0DE0000, 0};
        tbl[5] = '{1, 0, 0, 4'b1111, 1, 4'b0001, 1, 32'hC0DE0000, 0};
        tbl[6] = '{1, 0, 0, 4'b1111, 1, 4'b0010, 1, 32'hC0DE0001, 1};
        tbl[7] = '{1, 0, 0, 4'b0001, 1, 4'b0001, 1, 32'hC0DE0000, 0};
        tbl[8] = '{1, 0, 0, 4'b1001, 1, 4'b1000, 1, 32'hC0DE0003, 3};

        for (int v = 0; v < 9; v++) begin
            set_in(tbl[v].rr, tbl[v].sel, tbl[v].fl, tbl[v].iv, tbl[v].ordy);
            pre();
            chk($sformatf("tbl%0d_in_ready", v), 64'(in_ready), 64'(tbl[v].e_ir));
            post();
            chk($sformatf("tbl%0d_out_valid", v), 64'(out_valid), 64'(tbl[v].e_ov));
            chk($sformatf("tbl%0d_out_data", v),  64'(out_data),  64'(tbl[v].e_data));
            chk($sformatf("tbl%0d_out_chan", v),  64'(out_chan),  64'(tbl[v].e_chan));
        end

        // Back-pressure: hold 0xA5 for 3 stalled cycles, then load 0x5A without a bubble
        din[0] = 32'hA5;
        din[1] = 32'h5A;
        set_in(0, 0, 0, 4'b0001, 1);
        pre(); post();
        chk("bp_load_a5", 64'(out_data), 64'hA5);
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 0, 4'b0010, 0);
            pre();
            chk("bp_stall_ready", 64'(in_ready), 0);
            post();
            chk("bp_hold_data", 64'(out_data), 64'hA5);
            chk("bp_hold_valid", 64'(out_valid), 1);
        end
        set_in(0, 1, 0, 4'b0010, 1);
        pre();
        chk("bp_release_ready", 64'(in_ready), 64'b0010);
        post();
        chk("bp_new_data", 64'(out_data), 64'h5A);
        chk("bp_no_bubble", 64'(out_valid), 1);

        // Round-robin fairness from reset
        rst_n = 1'b0; #1; rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < C; i++) din[i] = 32'h10 + W'(i);
        for (int k = 0; k < 8; k++) begin
            set_in(1, 0, 0, 4'b1111, 1);
            pre(); post();
            chk("rr_seq_chan", 64'(out_chan), 64'(k % C));
            chk("rr_seq_data", 64'(out_data), 64'(32'h10 + (k % C)));
            chk("rr_seq_valid", 64'(out_valid), 1);
        end

        // Asynchronous reset mid-stream while the buffer is full
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_out_data",  64'(out_data), 0);
        chk("arst_out_chan",  64'(out_chan), 0);
        rst_n = 1'b1;
        model_reset();
        #0;
        set_in(1, 0, 0, 4'b1111, 1);
        pre();
        chk("arst_first_ready", 64'(in_ready), 64'b0001);
        post();
        chk("arst_first_chan", 64'(out_chan), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rr_en     = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, C - 1));
            flush     = ($urandom_range(0, 9) == 0);
            in_valid  = C'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < C; i++) din[i] = $urandom;
            pre(); post();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
